// File: rtl/window3x3_gen_pkg.sv
// Shared widths, window tap layout and FSM encoding for the 3x3 window generator.
package window3x3_gen_pkg;

    // Default pixel width and the packed 3x3 matrix width consumed by filter3x3
    localparam int unsigned IMG_DATA_WIDTH        = 8;
    localparam int unsigned IMG_DATA_MATRIX_WIDTH = 9 * IMG_DATA_WIDTH;

    // Tap LSB offsets for the default width: TAP_rc is row r, column c (row-major, TAP_00 at the MSBs)
    localparam int unsigned TAP_00 = 8 * IMG_DATA_WIDTH;
    localparam int unsigned TAP_01 = 7 * IMG_DATA_WIDTH;
    localparam int unsigned TAP_02 = 6 * IMG_DATA_WIDTH;
    localparam int unsigned TAP_10 = 5 * IMG_DATA_WIDTH;
    localparam int unsigned TAP_11 = 4 * IMG_DATA_WIDTH;
    localparam int unsigned TAP_12 = 3 * IMG_DATA_WIDTH;
    localparam int unsigned TAP_20 = 2 * IMG_DATA_WIDTH;
    localparam int unsigned TAP_21 = 1 * IMG_DATA_WIDTH;
    localparam int unsigned TAP_22 = 0;

    // FILL while rows 0-1 prime the line buffers, RUN once full 3-row neighbourhoods exist
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // LSB of tap (r,c) inside a packed window of pixel width dw
    function automatic int unsigned tap_lsb(input int unsigned r, input int unsigned c,
                                            input int unsigned dw);
        return (8 - (r * 3 + c)) * dw;
    endfunction

endpackage

// File: rtl/window3x3_gen_line_buffer2.sv
// Two stacked line buffers sharing one column index; read-before-write on we.
module window3x3_gen_line_buffer2 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IW-1:0]         idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] top_rd,
    output logic [DATA_WIDTH-1:0] mid_rd
);

    logic [DATA_WIDTH-1:0] lb_top [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] lb_mid [0:DEPTH-1];

    // Combinational read returns the pre-write contents of the column
    assign top_rd = lb_top[idx];
    assign mid_rd = lb_mid[idx];

    // Push the column up one line: mid moves to top, the new pixel lands in mid
    always_ff @(posedge clk) begin
        if (we) begin
            lb_top[idx] <= lb_mid[idx];
            lb_mid[idx] <= wdata;
        end
    end

endmodule

// File: rtl/window3x3_gen.sv
// Raster-stream 3x3 window producer feeding filter3x3; emits interior windows only.
module window3x3_gen
    import window3x3_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IMG_DATA_WIDTH,
    parameter int unsigned IMG_W      = 8,
    parameter int unsigned IMG_H      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_pixel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [9*DATA_WIDTH-1:0] out_window,
    output logic                    frame_done
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned MW = 9 * DATA_WIDTH;

    state_t                  state;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [DATA_WIDTH-1:0]   win    [0:2][0:2];
    logic [DATA_WIDTH-1:0]   nw     [0:2][0:2];
    logic [MW-1:0]           nw_packed;
    logic [DATA_WIDTH-1:0]   lb_top_rd;
    logic [DATA_WIDTH-1:0]   lb_mid_rd;
    logic                    accept;
    logic                    taken;
    logic                    col_last;
    logic                    row_last;
    logic                    emit;

    // Stall the input only while a window is held waiting for downstream
    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign taken    = out_valid && out_ready;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign emit     = accept && (state == RUN) && (col >= CW'(2));

    window3x3_gen_line_buffer2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_W),
        .IW         (CW)
    ) u_lb (
        .clk    (clk),
        .we     (accept),
        .idx    (col),
        .wdata  (in_pixel),
        .top_rd (lb_top_rd),
        .mid_rd (lb_mid_rd)
    );

    // Next window: shift left one column, new column {top, mid, incoming} enters on the right
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                nw[r][c] = win[r][c+1];
            end
        end
        nw[0][2] = lb_top_rd;
        nw[1][2] = lb_mid_rd;
        nw[2][2] = in_pixel;
    end

    // Pack the next window row-major with the top-left tap in the MSBs
    always_comb begin
        nw_packed = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                nw_packed[tap_lsb(r, c, DATA_WIDTH) +: DATA_WIDTH] = nw[r][c];
            end
        end
    end

    // 3x3 window registers advance on every accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            win <= nw;
        end
    end

    // Raster position counters and FILL/RUN control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col   <= '0;
            row   <= '0;
            state <= FILL;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
            case (state)
                FILL: if (col_last && (row == RW'(1)))  state <= RUN;
                RUN:  if (col_last && row_last)         state <= FILL;
                default:                                state <= FILL;
            endcase
        end
    end

    // Output window register: load on emit, drop once taken, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_window <= '0;
        end else if (emit) begin
            out_valid  <= 1'b1;
            frame_done <= col_last && row_last;
            out_window <= nw_packed;
        end else if (taken) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen: 4x4 frames on one instance, a 5x3 frame on another.
module tb_window3x3_gen;

    localparam int unsigned DW = 8;
    localparam int unsigned MW = 9 * DW;

    typedef struct {
        logic [MW-1:0] win;
        logic          fd;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, frame_done;
    logic [DW-1:0] in_pixel;
    logic [MW-1:0] out_window;
    logic          in_valid_b, in_ready_b, out_valid_b, out_ready_b, frame_done_b;
    logic [DW-1:0] in_pixel_b;
    logic [MW-1:0] out_window_b;

    int   tests = 0;
    int   fails = 0;
    vec_t exp_q[$];
    vec_t got_q[$];
    vec_t got_b[$];

    logic [MW-1:0] prev_win;
    logic          prev_stall = 1'b0;

    always #5 clk = ~clk;

    window3x3_gen #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .frame_done (frame_done)
    );

    window3x3_gen #(.DATA_WIDTH(DW), .IMG_W(5), .IMG_H(3)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .in_pixel   (in_pixel_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .out_window (out_window_b),
        .frame_done (frame_done_b)
    );

    function automatic logic [MW-1:0] pack9(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8);
        return {8'(a0), 8'(a1), 8'(a2), 8'(a3), 8'(a4), 8'(a5), 8'(a6), 8'(a7), 8'(a8)};
    endfunction

    function automatic logic is_trig(input int p);
        return (p == 11) || (p == 12) || (p == 15) || (p == 16);
    endfunction

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Capture every taken window; while stalled the held window must not move
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", MW'(out_valid), MW'(1));
                check("hold_window", out_window, prev_win);
            end
            if (out_valid && out_ready) got_q.push_back('{out_window, frame_done});
            if (out_valid_b && out_ready_b) got_b.push_back('{out_window_b, frame_done_b});
            prev_stall = out_valid && !out_ready;
            prev_win   = out_window;
        end
    end

    // Present one pixel until accepted (bounded), then check out_valid one cycle later
    task automatic send(input int p, input int base);
        int   n;
        logic ok;
        in_valid = 1'b1;
        in_pixel = 8'(p);
        n = 0;
        do begin
            #1;
            ok = in_ready;
            @(posedge clk);
            #2;
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: pixel %0d not accepted, required accept within 50 cycles", p);
        end else begin
            check($sformatf("latency_p%0d", p), MW'(out_valid), MW'(is_trig(p - base)));
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic compare(input string name, input int which);
        int sz;
        sz = (which == 0) ? got_q.size() : got_b.size();
        check({name, "_count"}, MW'(sz), MW'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sz; i++) begin
            vec_t g;
            g = (which == 0) ? got_q[i] : got_b[i];
            check($sformatf("%s_win%0d", name, i), g.win, exp_q[i].win);
            check($sformatf("%s_fd%0d", name, i), MW'(g.fd), MW'(exp_q[i].fd));
        end
        got_q.delete();
        got_b.delete();
    endtask

    task automatic load_frame1(input int base);
        exp_q.push_back('{pack9(base+1, base+2, base+3, base+5, base+6, base+7, base+9, base+10, base+11), 1'b0});
        exp_q.push_back('{pack9(base+2, base+3, base+4, base+6, base+7, base+8, base+10, base+11, base+12), 1'b0});
        exp_q.push_back('{pack9(base+5, base+6, base+7, base+9, base+10, base+11, base+13, base+14, base+15), 1'b0});
        exp_q.push_back('{pack9(base+6, base+7, base+8, base+10, base+11, base+12, base+14, base+15, base+16), 1'b1});
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_pixel    = '0;
        out_ready   = 1'b1;
        in_valid_b  = 1'b0;
        in_pixel_b  = '0;
        out_ready_b = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", MW'(out_valid), MW'(0));
        check("rst_frame_done", MW'(frame_done), MW'(0));
        check("rst_out_window", out_window, MW'(0));
        check("rst_in_ready", MW'(in_ready), MW'(1));
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Continuous 4x4 frame
        exp_q.delete();
        load_frame1(0);
        for (int p = 1; p <= 16; p++) send(p, 0);
        idle(3);
        compare("cont", 0);

        // Downstream stall of 3 cycles after the first window
        fork
            begin
                wait (out_valid === 1'b1);
                #1;
                out_ready = 1'b0;
                #1;
                check("stall_in_ready", MW'(in_ready), MW'(0));
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        for (int p = 1; p <= 16; p++) send(p, 0);
        idle(3);
        compare("stall", 0);

        // in_valid toggling every cycle
        for (int p = 1; p <= 16; p++) begin
            send(p, 0);
            idle(1);
            if (is_trig(p)) check($sformatf("toggle_taken_p%0d", p), MW'(out_valid), MW'(0));
        end
        idle(2);
        compare("toggle", 0);

        // Two frames back to back
        exp_q.delete();
        load_frame1(0);
        load_frame1(100);
        for (int p = 1; p <= 16; p++) send(p, 0);
        for (int p = 101; p <= 116; p++) send(p, 100);
        idle(3);
        compare("b2b", 0);

        // Reset mid-frame, then a clean frame
        exp_q.delete();
        load_frame1(0);
        for (int p = 1; p <= 7; p++) send(p, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", MW'(out_valid), MW'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        for (int p = 1; p <= 16; p++) send(p, 0);
        idle(3);
        compare("midrst", 0);

        // 5x3 frame on the second instance: only columns 2..4 of row 2 emit
        exp_q.delete();
        exp_q.push_back('{pack9(1, 2, 3, 6, 7, 8, 11, 12, 13), 1'b0});
        exp_q.push_back('{pack9(2, 3, 4, 7, 8, 9, 12, 13, 14), 1'b0});
        exp_q.push_back('{pack9(3, 4, 5, 8, 9, 10, 13, 14, 15), 1'b1});
        for (int p = 1; p <= 15; p++) begin
            in_valid_b = 1'b1;
            in_pixel_b = 8'(p);
            @(posedge clk);
            #2;
            check($sformatf("w5h3_valid_p%0d", p), MW'(out_valid_b), MW'(p >= 13));
        end
        in_valid_b = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        compare("w5h3", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
